// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer:
// the FSM state type and the default frame width.
package piso_serializer_pkg;

    localparam int PISO_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } piso_state_e;

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake, shift strobe and serial output bundle of the serializer.
// The master side offers words and steps bits; the slave side is the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = piso_serializer_pkg::PISO_WIDTH_DEF
);

    logic                       load_valid;
    logic                       load_ready;
    logic [WIDTH-1:0]           load_data;
    logic                       shift_en;
    logic                       sout;
    logic                       sout_valid;
    logic                       last;
    logic [$clog2(WIDTH)-1:0]   bit_cnt;
    logic                       done;
    logic                       busy;

    modport master (
        output load_valid,
        output load_data,
        output shift_en,
        input  load_ready,
        input  sout,
        input  sout_valid,
        input  last,
        input  bit_cnt,
        input  done,
        input  busy
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  shift_en,
        output load_ready,
        output sout,
        output sout_valid,
        output last,
        output bit_cnt,
        output done,
        output busy
    );

endinterface

// File: rtl/piso_bit_counter.sv
// Index of the frame bit currently on the serial output, with a terminal-count
// flag raised when the last bit of the frame is being presented.
module piso_bit_counter #(
    parameter int WIDTH = piso_serializer_pkg::PISO_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     inc,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     tc
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_r;

    // Counter register: clear wins over increment so a new frame always starts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (inc) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
    assign tc  = (cnt_r == CNT_LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer: accepts one WIDTH-bit word, presents it
// one bit per shift_en strobe, then pulses done for a single cycle.
module piso_serializer #(
    parameter int WIDTH     = piso_serializer_pkg::PISO_WIDTH_DEF,
    parameter int MSB_FIRST = 1
) (
    input  logic               clk,
    input  logic               rst,
    piso_serializer_if.slave   bus
);

    import piso_serializer_pkg::*;

    localparam int CW = $clog2(WIDTH);

    piso_state_e      state_r;
    piso_state_e      state_next_s;
    logic [WIDTH-1:0] shift_reg_r;
    logic [WIDTH-1:0] shift_reg_next_s;
    logic [WIDTH-1:0] shift_step_s;
    logic             load_take_s;
    logic             cnt_clr_s;
    logic             cnt_inc_s;
    logic [CW-1:0]    cnt_s;
    logic             cnt_tc_s;
    logic             sout_bit_s;

    // The output end of the register depends on the bit order; zeros are shifted in behind.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign shift_step_s = {shift_reg_r[WIDTH-2:0], 1'b0};
            assign sout_bit_s   = shift_reg_r[WIDTH-1];
        end else begin : g_lsb_first
            assign shift_step_s = {1'b0, shift_reg_r[WIDTH-1:1]};
            assign sout_bit_s   = shift_reg_r[0];
        end
    endgenerate

    assign load_take_s = (state_r == ST_IDLE) && bus.load_valid;
    // Clearing in DONE leaves bit_cnt at 0 whenever the serializer is idle.
    assign cnt_clr_s   = load_take_s || (state_r == ST_DONE);
    assign cnt_inc_s   = (state_r == ST_SHIFT) && bus.shift_en && !cnt_tc_s;

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr_s),
        .inc (cnt_inc_s),
        .cnt (cnt_s),
        .tc  (cnt_tc_s)
    );

    // State and data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            shift_reg_r <= {WIDTH{1'b0}};
        end else begin
            state_r     <= state_next_s;
            shift_reg_r <= shift_reg_next_s;
        end
    end

    // Next-state and next-data decode; shift_en is only honoured in SHIFT.
    always_comb begin
        state_next_s     = state_r;
        shift_reg_next_s = shift_reg_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.load_valid) begin
                    state_next_s     = ST_SHIFT;
                    shift_reg_next_s = bus.load_data;
                end else begin
                    state_next_s     = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bus.shift_en) begin
                    if (cnt_tc_s) begin
                        state_next_s     = ST_DONE;
                    end else begin
                        state_next_s     = ST_SHIFT;
                        shift_reg_next_s = shift_step_s;
                    end
                end else begin
                    state_next_s     = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s     = ST_IDLE;
                shift_reg_next_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // Outputs decode from registered state only, so no input reaches them combinationally.
    assign bus.load_ready = (state_r == ST_IDLE);
    assign bus.sout_valid = (state_r == ST_SHIFT);
    assign bus.sout       = (state_r == ST_SHIFT) ? sout_bit_s : 1'b0;
    assign bus.last       = (state_r == ST_SHIFT) && cnt_tc_s;
    assign bus.bit_cnt    = cnt_s;
    assign bus.done       = (state_r == ST_DONE);
    assign bus.busy       = (state_r == ST_SHIFT) || (state_r == ST_DONE);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first and an LSB-first instance
// receive identical stimulus and are each checked against hand-derived bits.
module tb_piso_serializer;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    piso_serializer_if #(.WIDTH(8)) ifm ();
    piso_serializer_if #(.WIDTH(8)) ifl ();

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (.clk(clk), .rst(rst), .bus(ifm));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (.clk(clk), .rst(rst), .bus(ifl));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lv, input logic [7:0] ld, input logic se);
        ifm.load_valid = lv;  ifl.load_valid = lv;
        ifm.load_data  = ld;  ifl.load_data  = ld;
        ifm.shift_en   = se;  ifl.shift_en   = se;
    endtask

    // Bit idx of a frame: MSB-first sends word[7-idx], LSB-first sends word[idx].
    task automatic check_bit(input string tag, input int idx, input logic [7:0] word);
        logic [7:0] w;
        w = word;
        chk({tag, "_msb_sout"},  {31'd0, ifm.sout},       {31'd0, w[7-idx]});
        chk({tag, "_lsb_sout"},  {31'd0, ifl.sout},       {31'd0, w[idx]});
        chk({tag, "_msb_valid"}, {31'd0, ifm.sout_valid}, 32'd1);
        chk({tag, "_lsb_valid"}, {31'd0, ifl.sout_valid}, 32'd1);
        chk({tag, "_msb_cnt"},   {29'd0, ifm.bit_cnt},    idx);
        chk({tag, "_lsb_cnt"},   {29'd0, ifl.bit_cnt},    idx);
        chk({tag, "_msb_last"},  {31'd0, ifm.last},       (idx == 7) ? 32'd1 : 32'd0);
        chk({tag, "_lsb_last"},  {31'd0, ifl.last},       (idx == 7) ? 32'd1 : 32'd0);
        chk({tag, "_msb_ready"}, {31'd0, ifm.load_ready}, 32'd0);
        chk({tag, "_msb_busy"},  {31'd0, ifm.busy},       32'd1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_msb_ready"}, {31'd0, ifm.load_ready}, 32'd1);
        chk({tag, "_lsb_ready"}, {31'd0, ifl.load_ready}, 32'd1);
        chk({tag, "_msb_sout"},  {31'd0, ifm.sout},       32'd0);
        chk({tag, "_msb_valid"}, {31'd0, ifm.sout_valid}, 32'd0);
        chk({tag, "_lsb_valid"}, {31'd0, ifl.sout_valid}, 32'd0);
        chk({tag, "_msb_last"},  {31'd0, ifm.last},       32'd0);
        chk({tag, "_msb_done"},  {31'd0, ifm.done},       32'd0);
        chk({tag, "_lsb_done"},  {31'd0, ifl.done},       32'd0);
        chk({tag, "_msb_busy"},  {31'd0, ifm.busy},       32'd0);
        chk({tag, "_lsb_busy"},  {31'd0, ifl.busy},       32'd0);
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_msb_done"},  {31'd0, ifm.done},       32'd1);
        chk({tag, "_lsb_done"},  {31'd0, ifl.done},       32'd1);
        chk({tag, "_msb_valid"}, {31'd0, ifm.sout_valid}, 32'd0);
        chk({tag, "_msb_ready"}, {31'd0, ifm.load_ready}, 32'd0);
        chk({tag, "_msb_busy"},  {31'd0, ifm.busy},       32'd1);
    endtask

    // Full frame with shift_en high throughout, including the load cycle.
    // Cycle 0 is the acceptance cycle; bits occupy cycles 1..8, done cycle 9, ready cycle 10.
    task automatic run_frame(input string tag, input logic [7:0] word);
        drive(1'b1, word, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check_bit(tag, i, word);
            step();
        end
        check_done(tag);
        step();
        check_idle({tag, "_ready10"});
    endtask

    initial begin
        int idx;
        logic se;

        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        step();
        step();
        check_idle("reset");
        chk("reset_msb_cnt", {29'd0, ifm.bit_cnt}, 32'd0);
        rst = 1'b0;

        // shift_en in IDLE must not start anything.
        drive(1'b0, 8'h00, 1'b1);
        step();
        step();
        check_idle("idle_shift_en");

        // 8'hA5 with shift_en held high (load and shift_en together in IDLE).
        run_frame("a5", 8'hA5);

        // 8'h01: MSB-first gives 0..0,1; LSB-first gives 1,0..0.
        run_frame("h01", 8'h01);

        // 8'hF0 with shift_en pattern 1,0,0,1,0,0,...: each bit holds while stalled.
        drive(1'b1, 8'hF0, 1'b0);
        step();
        idx = 0;
        for (int j = 0; j < 40 && idx < 8; j++) begin
            check_bit("f0_hold", idx, 8'hF0);
            se = ((j % 3) == 0);
            drive(1'b0, 8'h00, se);
            step();
            if (se) idx++;
        end
        check_done("f0");
        step();
        check_idle("f0_end");

        // Load attempts while busy are ignored and never sent.
        drive(1'b1, 8'h5A, 1'b1);
        step();
        drive(1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check_bit("busy_load", i, 8'h5A);
            step();
        end
        drive(1'b0, 8'h00, 1'b1);
        check_done("busy_load");
        step();
        check_idle("busy_load_end");
        step();
        check_idle("busy_load_nosend");

        // Reset in the middle of a frame aborts it without a done pulse.
        drive(1'b1, 8'h3C, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) step();
        check_bit("pre_rst", 3, 8'h3C);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("mid_rst");
        chk("mid_rst_msb_cnt", {29'd0, ifm.bit_cnt}, 32'd0);
        step();
        check_idle("mid_rst_nodone");
        run_frame("h3c", 8'h3C);

        // 8'h80 loaded with shift_en high: first bit still held a full cycle.
        run_frame("h80", 8'h80);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
